// File: rtl/keycode_event_queue.sv
// Debounces HID keycodes from the keycode PIO and queues timestamped
// press/release events for the four rhythm-game lanes (D F J K).
module keycode_event_queue #(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 8,
    parameter int STAMP_W       = 13
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [7:0]               keycode,
    input  logic                     frame_tick,
    input  logic                     pop,
    input  logic                     clear_ovf,
    output logic                     evt_valid,
    output logic [STAMP_W+2:0]       evt_data,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic [3:0]               lane_held,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = STAMP_W + 3;
    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EMIT_REL   = 2'd1,
        EMIT_PRESS = 2'd2
    } state_t;

    // Returns {mapped, lane[1:0]}
    function automatic logic [2:0] lane_of(input logic [7:0] code);
        logic [2:0] r;
        case (code)
            8'h07:   r = 3'b100;
            8'h09:   r = 3'b101;
            8'h0D:   r = 3'b110;
            8'h0E:   r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [7:0]          cand_q, cand_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [7:0]          acc_q, acc_d;
    logic [1:0]          old_lane_q, old_lane_d;
    logic [STAMP_W-1:0]  stamp_q, stamp_d;
    logic [DW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;

    logic                accept;
    logic [2:0]          cand_lane, acc_lane;
    logic                wr_req;
    logic [DW-1:0]       wr_data;
    logic                full, pop_ok, wr_ok, drop;

    assign cand_lane = lane_of(cand_q);
    assign acc_lane  = lane_of(acc_q);

    // Counter saturates at the threshold so a change seen during an emit
    // is still accepted once the FSM is back in IDLE.
    always_comb begin
        cand_d = keycode;
        if (keycode != cand_q) begin
            cnt_d = 4'd1;
        end else if (cnt_q == STABLE) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    assign accept = (state_q == IDLE) && (cnt_q == STABLE)
                    && (cand_q != acc_q);

    always_comb begin
        acc_d      = acc_q;
        old_lane_d = old_lane_q;
        if (accept) begin
            acc_d      = cand_q;
            old_lane_d = acc_lane[1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (acc_lane[2]) begin
                        state_d = EMIT_REL;
                    end else if (cand_lane[2]) begin
                        state_d = EMIT_PRESS;
                    end
                end
            end
            EMIT_REL:   state_d = acc_lane[2] ? EMIT_PRESS : IDLE;
            EMIT_PRESS: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_req  = 1'b0;
        wr_data = '0;
        unique case (state_q)
            EMIT_REL: begin
                wr_req  = 1'b1;
                wr_data = {1'b0, old_lane_q, stamp_q};
            end
            EMIT_PRESS: begin
                wr_req  = 1'b1;
                wr_data = {1'b1, acc_lane[1:0], stamp_q};
            end
            default: begin
                wr_req  = 1'b0;
                wr_data = '0;
            end
        endcase
    end

    assign stamp_d = frame_tick ? stamp_q + 1'b1 : stamp_q;

    assign full   = (count_q == CW'(DEPTH));
    assign pop_ok = pop && (count_q != '0);
    assign wr_ok  = wr_req && (!full || pop);
    assign drop   = wr_req && full && !pop;

    always_comb begin
        count_d = count_q;
        if (wr_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!wr_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cand_q     <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            old_lane_q <= '0;
            stamp_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            old_lane_q <= old_lane_d;
            stamp_q    <= stamp_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;
    assign evt_count = count_q;
    assign lane_held = acc_lane[2] ? (4'b0001 << acc_lane[1:0]) : 4'b0000;
    assign overflow  = ovf_q;

endmodule

// File: doc/keycode_event_queue.md
KEYCODE_EVENT_QUEUE -- requirements
Module: keycode_event_queue

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical keycode samples required before a key change is accepted (range 1..15).
REQ-002 Parameter DEPTH, default 8: event FIFO depth in entries (power of 2).
REQ-003 Parameter STAMP_W, default 13: width of the frame timestamp field.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 keycode  input  8  USB HID keycode from the NIOS keycode PIO; 0x00 means no key.
REQ-007 frame_tick  input  1  one-cycle pulse marking the start of each video frame.
REQ-008 pop  input  1  consumer removes the head event this cycle.
REQ-009 clear_ovf  input  1  clears the sticky overflow flag.
REQ-010 evt_valid  output  1  FIFO is non-empty; evt_data is valid.
REQ-011 evt_data  output  STAMP_W+3  head event {press, lane[1:0], stamp}.
REQ-012 evt_count  output  $clog2(DEPTH)+1  number of queued events.
REQ-013 lane_held  output  4  one-hot currently accepted lane; 0 if none.
REQ-014 overflow  output  1  sticky: an event was dropped.

Function
REQ-015 Lane map SHALL be: 0x07 (D) -> lane 0, 0x09 (F) -> lane 1, 0x0D (J) -> lane 2, 0x0E (K) -> lane 3; every other code is unmapped.
REQ-016 Filter: candidate register tracks keycode; counter resets to 1 when keycode != candidate and increments (saturating) while equal; acceptance occurs when counter == STABLE_CYCLES and candidate != accepted code.
REQ-017 FSM states IDLE, EMIT_REL, EMIT_PRESS, evaluated once per cycle.
REQ-018 IDLE -> EMIT_REL on acceptance if old accepted code is mapped, else -> EMIT_PRESS if new code is mapped, else stay IDLE; accepted code updates on acceptance in all cases.
REQ-019 EMIT_REL writes {0, old lane, stamp}; then -> EMIT_PRESS if new code is mapped, else -> IDLE.
REQ-020 EMIT_PRESS writes {1, new lane, stamp}, then -> IDLE.
REQ-021 A direct change between two mapped keys SHALL produce release-then-press in consecutive FIFO entries.
REQ-022 Keycode changes during EMIT states are filtered normally but not accepted until FSM returns to IDLE.
REQ-023 lane_held SHALL update in the same cycle the accepted code updates.
REQ-024 stamp is a STAMP_W counter incremented on each frame_tick, wrapping from all-ones to 0; the written stamp is the value before any same-cycle increment.
REQ-025 Latency: a mapped keycode applied at cycle 0 from 0x00 and held SHALL give evt_valid=1 at cycle STABLE_CYCLES+2.
REQ-026 Write when full without same-cycle pop SHALL drop the event and set overflow; write when full with pop SHALL be accepted.
REQ-027 pop when empty SHALL be ignored; evt_count never underflows.
REQ-028 clear_ovf clears overflow unless a drop occurs the same cycle (set wins).
REQ-029 evt_data SHALL be 0 when evt_valid=0.

Reset
REQ-030 Reset SHALL clear FIFO pointers and contents, evt_count, overflow, stamp, filter counter and candidate (to 0x00), accepted code (to 0x00), lane_held, and force FSM to IDLE, including mid-emit; all outputs read 0 the cycle after Reset.

Verification
REQ-031 Keycode 0x00 -> 0x07 held 10 cycles, stamp 5 -> evt_valid at cycle 6, evt_data {1,00,5}, lane_held=0001.
REQ-032 0x09 glitch for 3 cycles then back to 0x00 (STABLE_CYCLES=4) -> no event, lane_held unchanged.
REQ-033 Accepted 0x07, keycode -> 0x0E held -> two entries {0,00,s} then {1,11,s}, evt_count=2, lane_held=1000.
REQ-034 Fill 8 events, no pop, one more change -> overflow=1, evt_count=8; repeat with pop on the write cycle -> overflow stays 0, count stays 8.
REQ-035 Stamp at all-ones, frame_tick on the write cycle -> entry carries all-ones stamp, next entry carries 0.
REQ-036 Reset asserted during EMIT_REL -> next cycle evt_valid=0, lane_held=0, FSM IDLE, no event written.
